updown_dir_ctrl: RTL and testbench
==================================

Name: updown_dir_ctrl

Overview:
- Front-end control stage that feeds the 3-bit up/down counter.
- Converts three raw, asynchronous, bouncy push-buttons (count up, count down, clear) into clean single-clock-domain controls.
- Outputs are the counter's `up` direction level and a one-cycle `clr` pulse, which the top level ORs into the counter's `reset`.
- Sits directly upstream of up_down_counter. All outputs are registered.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples a button must hold a new level before it is accepted; legal range 2..255.
- DB_W, 8: width of each debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  raw "count up" button, asynchronous, active-high.
- btn_down  input  1  raw "count down" button, asynchronous, active-high.
- btn_clr  input  1  raw "clear" button, asynchronous, active-high.
- up  output  1  direction to counter; 1 = up, 0 = down.
- clr  output  1  one-cycle clear-request pulse.
- dir_changed  output  1  one-cycle pulse when `up` changes value.
- conflict  output  1  one-cycle pulse when up and down presses are accepted on the same cycle.

Behaviour:
- Interface: one clock, `clk`. Reset is `reset`, synchronous and active-high.
- Reset values:
  - Outputs: up=0, clr=0, dir_changed=0, conflict=0.
  - Internal: all synchronizer flops 0, all debounced levels 0, all debounce counters 0, direction state DOWN.
- Per button, in this order:
  - Two-flop synchronizer produces s2.
  - Debouncer holds accepted level `db` and counter `cnt`.
    - If s2 == db: cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
    - Else: cnt <= cnt+1.
  - Any bounce back to db restarts the count.
  - Press event = db rising (0->1). Releases generate no event.
- Latency: a clean input level change is reflected in `db` DEBOUNCE_CYCLES+1 edges after the edge that first captures it in s1. Output reaction follows one edge later, i.e. DEBOUNCE_CYCLES+2 edges total (6 for the default).
- Direction FSM, states DOWN (up=0) and UP (up=1):
  - DOWN + up-press only -> UP, dir_changed=1.
  - UP + down-press only -> DOWN, dir_changed=1.
  - Press toward the current direction: no change, no pulse.
  - Up-press and down-press on the same cycle: state holds, conflict=1, dir_changed=0.
- Clear:
  - clr-press -> clr=1 for exactly one cycle.
  - Direction is unaffected.
  - A held clr button produces no further pulses until it is released and pressed again.
- Simultaneous clr-press and direction press on the same cycle: both take effect in that cycle.
- Reset mid-debounce: counters are cleared, and presses in progress are discarded. A button still held at reset release must be accepted again via the full debounce, which yields a fresh press event.
- Pulse outputs (clr, dir_changed, conflict) are never high for two consecutive cycles from a single press.

Optional Feature:
- Macro: UPDOWN_DIR_TOGGLE_EN.
- When defined:
  - btn_down is ignored; its synchronizer and debouncer still exist, but its press events are unused.
  - Each accepted btn_up press toggles the direction, with dir_changed=1 on every toggle.
  - conflict is tied 0.
- When undefined: behaviour is exactly as above.

Decomposition:
- Package updown_pkg:
  - Direction constants DIR_DOWN=1'b0, DIR_UP=1'b1.
  - FSM state encoding.
  - Default DEBOUNCE_CYCLES value.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES, DB_W):
  - Ports clk, reset, btn_raw, level, press.
  - Contains the synchronizer, debounce counter and rise detector.
  - Instantiated three times.
- The direction FSM and pulse logic stay in updown_dir_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, clk period 20):
- Reset:
  - Hold reset 2 cycles with all buttons at 1.
  - up=0, clr=0, dir_changed=0, conflict=0 throughout.
  - After release: up=1 and dir_changed=1 six edges later; up stays 1 while btn_up remains held.
- Clean press:
  - btn_up 0->1 held 10 cycles -> up=1 exactly 6 edges after first capture, with a one-cycle dir_changed.
  - Then btn_down press -> up=0, dir_changed pulses once.
- Bounce rejection:
  - btn_down toggling 1,0,1,0 every cycle, then held -> no change until 4 stable samples.
  - Glitch of 3 cycles -> no dir_changed, up unchanged.
- Conflict: btn_up and btn_down rise on the same edge, held 10 cycles -> conflict one-cycle pulse, up unchanged, dir_changed=0.
- Clear: btn_clr held 20 cycles -> single one-cycle clr pulse; up retains its prior value 1; release and re-press -> second pulse.
- Toggle build (UPDOWN_DIR_TOGGLE_EN defined):
  - Three separate btn_up presses -> up sequence 1,0,1, each with a dir_changed pulse.
  - btn_down presses -> no effect.

Source files
------------

// File: rtl/updown_pkg.sv
// -----------------------------------------------------------------------------
// updown_pkg
// Shared definitions for the up/down counter front-end control stage:
//   - direction encodings as seen by up_down_counter (DIR_DOWN / DIR_UP)
//   - direction FSM state encoding
//   - default debounce length and counter width
//   - helper that maps an FSM state onto the counter's `up` level
// -----------------------------------------------------------------------------
package updown_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // State encoding deliberately matches the direction level it drives.
  typedef enum logic {
    ST_DOWN = 1'b0,
    ST_UP   = 1'b1
  } dir_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd4;
  localparam int unsigned DB_W_DEFAULT            = 32'd8;

  function automatic logic state_to_dir(input dir_state_e state);
    return (state == ST_UP) ? DIR_UP : DIR_DOWN;
  endfunction

endpackage

// File: rtl/updown_dir_ctrl_if.sv
// -----------------------------------------------------------------------------
// updown_dir_ctrl_if
// Button-in / control-out bundle of updown_dir_ctrl.
//   btn_up, btn_down, btn_clr : raw asynchronous active-high push-buttons
//   up                        : counter direction (1 = up, 0 = down)
//   clr                       : one-cycle clear-request pulse
//   dir_changed               : one-cycle pulse when `up` changes
//   conflict                  : one-cycle pulse on simultaneous up/down press
//   btn_level                 : debounced button levels {clr, down, up},
//                               for status display
// Modports: master = button/panel side, slave = updown_dir_ctrl.
// -----------------------------------------------------------------------------
interface updown_dir_ctrl_if;

  logic       btn_up;
  logic       btn_down;
  logic       btn_clr;
  logic       up;
  logic       clr;
  logic       dir_changed;
  logic       conflict;
  logic [2:0] btn_level;

  modport master (
    output btn_up, btn_down, btn_clr,
    input  up, clr, dir_changed, conflict, btn_level
  );

  modport slave (
    input  btn_up, btn_down, btn_clr,
    output up, clr, dir_changed, conflict, btn_level
  );

endinterface

// File: rtl/updown_dir_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One raw asynchronous button -> two-flop synchronizer -> counting debouncer
// -> rising-edge (press) detector.
// Parameters:
//   DEBOUNCE_CYCLES : consecutive synchronized samples a new level must hold
//                     before it is accepted (2..255)
//   DB_W            : debounce counter width, 2**DB_W > DEBOUNCE_CYCLES
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   btn_raw : raw asynchronous button input
//   level   : accepted (debounced) level, registered
//   press   : one-cycle pulse in the cycle after level is accepted 0->1
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd4,
  parameter int unsigned DB_W            = 32'd8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(32'd1);

  logic            s1_r;
  logic            s2_r;
  logic            db_r;
  logic            press_r;
  logic [DB_W-1:0] cnt_r;
  logic            accept_s;

  // New level has now been seen on enough consecutive samples.
  always_comb begin
    accept_s = (s2_r != db_r) && (cnt_r == CNT_LAST);
  end

  // Synchronizer, debounce counter, accepted level and press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      db_r    <= 1'b0;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      s1_r    <= btn_raw;
      s2_r    <= s1_r;
      // Press is registered together with db so it lines up with the new level.
      press_r <= accept_s & s2_r;
      if (s2_r == db_r) begin
        // Any bounce back to the accepted level restarts the count.
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        db_r  <= s2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level = db_r;
  assign press = press_r;

endmodule

// File: rtl/updown_dir_ctrl.sv
// -----------------------------------------------------------------------------
// updown_dir_ctrl
// Front-end control stage for the 3-bit up/down counter. Debounces the up,
// down and clear buttons and produces the registered direction level `up`,
// a one-cycle `clr` pulse (ORed into the counter reset at the top level),
// and one-cycle `dir_changed` / `conflict` status pulses.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : updown_dir_ctrl_if.slave (buttons in, controls/status out)
// Build option:
//   UPDOWN_DIR_TOGGLE_EN : btn_up presses toggle the direction, btn_down
//                          presses are ignored, conflict is tied low.
// -----------------------------------------------------------------------------
module updown_dir_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned DB_W            = DB_W_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  updown_dir_ctrl_if.slave  bus
);

  logic       lvl_up_s;
  logic       lvl_dn_s;
  logic       lvl_clr_s;
  logic       press_up_s;
  logic       press_dn_s;
  logic       press_clr_s;

  dir_state_e state_r;
  dir_state_e state_nxt_s;
  logic       up_r;
  logic       clr_r;
  logic       dir_changed_r;
  logic       conflict_r;
  logic       clr_nxt_s;
  logic       dir_changed_nxt_s;
  logic       conflict_nxt_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_up (
    .clk(clk), .reset(reset), .btn_raw(bus.btn_up),
    .level(lvl_up_s), .press(press_up_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_down (
    .clk(clk), .reset(reset), .btn_raw(bus.btn_down),
    .level(lvl_dn_s), .press(press_dn_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_clr (
    .clk(clk), .reset(reset), .btn_raw(bus.btn_clr),
    .level(lvl_clr_s), .press(press_clr_s)
  );

  // Direction FSM next state and next values of the pulse outputs.
  always_comb begin
    state_nxt_s       = state_r;
    dir_changed_nxt_s = 1'b0;
    conflict_nxt_s    = 1'b0;
    // Clear is independent of direction and may coincide with a direction change.
    clr_nxt_s         = press_clr_s;
`ifdef UPDOWN_DIR_TOGGLE_EN
    if (press_up_s) begin
      state_nxt_s       = (state_r == ST_UP) ? ST_DOWN : ST_UP;
      dir_changed_nxt_s = 1'b1;
    end else begin
      state_nxt_s       = state_r;
    end
`else
    case (state_r)
      ST_DOWN: begin
        if (press_up_s && press_dn_s) begin
          conflict_nxt_s    = 1'b1;
        end else if (press_up_s) begin
          state_nxt_s       = ST_UP;
          dir_changed_nxt_s = 1'b1;
        end else begin
          state_nxt_s       = ST_DOWN;
        end
      end
      ST_UP: begin
        if (press_up_s && press_dn_s) begin
          conflict_nxt_s    = 1'b1;
        end else if (press_dn_s) begin
          state_nxt_s       = ST_DOWN;
          dir_changed_nxt_s = 1'b1;
        end else begin
          state_nxt_s       = ST_UP;
        end
      end
      default: begin
        state_nxt_s = ST_DOWN;
      end
    endcase
`endif
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_DOWN;
      up_r          <= DIR_DOWN;
      clr_r         <= 1'b0;
      dir_changed_r <= 1'b0;
      conflict_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      up_r          <= state_to_dir(state_nxt_s);
      clr_r         <= clr_nxt_s;
      dir_changed_r <= dir_changed_nxt_s;
      conflict_r    <= conflict_nxt_s;
    end
  end

  assign bus.up          = up_r;
  assign bus.clr         = clr_r;
  assign bus.dir_changed = dir_changed_r;
  assign bus.conflict    = conflict_r;
  assign bus.btn_level   = {lvl_clr_s, lvl_dn_s, lvl_up_s};

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_dir_ctrl
// Directed table-driven bench for updown_dir_ctrl with DEBOUNCE_CYCLES=4.
// Each vector drives {reset, btn_up, btn_down, btn_clr} after a rising edge,
// waits for the next rising edge, then compares {up, clr, dir_changed,
// conflict} 1 time unit later. A clean press first captured on the edge of
// vector k shows its effect on vector k+6.
// -----------------------------------------------------------------------------
module tb_updown_dir_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #10 clk = ~clk;

  updown_dir_ctrl_if bus ();

  updown_dir_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // rst, buttons {up,down,clr}, expected {up,clr,dir_changed,conflict}
  typedef struct packed {
    logic       rst;
    logic [2:0] btn;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int n, input logic r, input logic [2:0] b, input logic [3:0] e);
    for (int i = 0; i < n; i++) vecs.push_back({r, b, e});
  endtask

  task automatic apply_check(input string name, input logic r, input logic [2:0] b,
                             input logic [3:0] e);
    logic [3:0] act;
    reset        = r;
    bus.btn_up   = b[2];
    bus.btn_down = b[1];
    bus.btn_clr  = b[0];
    @(posedge clk);
    #1;
    act   = {bus.up, bus.clr, bus.dir_changed, bus.conflict};
    n_vec = n_vec + 1;
    if (act !== e) begin
      n_err = n_err + 1;
      $display("FAIL %s: up/clr/dir_changed/conflict got %b expected %b", name, act, e);
    end
  endtask

  initial begin
`ifdef UPDOWN_DIR_TOGGLE_EN
    add(2, 1'b1, 3'b000, 4'b0000);   // reset
    add(4, 1'b0, 3'b100, 4'b0000);   // press 1
    add(2, 1'b0, 3'b000, 4'b0000);
    add(1, 1'b0, 3'b000, 4'b1010);   // -> up=1
    add(5, 1'b0, 3'b000, 4'b1000);
    add(4, 1'b0, 3'b100, 4'b1000);   // press 2
    add(2, 1'b0, 3'b000, 4'b1000);
    add(1, 1'b0, 3'b000, 4'b0010);   // -> up=0
    add(5, 1'b0, 3'b000, 4'b0000);
    add(4, 1'b0, 3'b010, 4'b0000);   // down press ignored
    add(8, 1'b0, 3'b000, 4'b0000);
    add(4, 1'b0, 3'b100, 4'b0000);   // press 3
    add(2, 1'b0, 3'b000, 4'b0000);
    add(1, 1'b0, 3'b000, 4'b1010);   // -> up=1
    add(5, 1'b0, 3'b000, 4'b1000);
`else
    add(2, 1'b1, 3'b111, 4'b0000);   // reset, all buttons held
    add(6, 1'b0, 3'b101, 4'b0000);   // up+clr held through release
    add(1, 1'b0, 3'b101, 4'b1110);   // 6 edges later: up, clr, dir_changed
    add(1, 1'b0, 3'b101, 4'b1000);
    add(6, 1'b0, 3'b000, 4'b1000);   // release: no events
    add(6, 1'b0, 3'b010, 4'b1000);   // clean down press
    add(1, 1'b0, 3'b010, 4'b0010);
    add(3, 1'b0, 3'b010, 4'b0000);
    add(6, 1'b0, 3'b000, 4'b0000);
    add(4, 1'b0, 3'b100, 4'b0000);   // minimum-length up press (4 samples)
    add(2, 1'b0, 3'b000, 4'b0000);
    add(1, 1'b0, 3'b000, 4'b1010);
    add(3, 1'b0, 3'b000, 4'b1000);
    add(1, 1'b0, 3'b010, 4'b1000);   // down bouncing 1,0,1,0
    add(1, 1'b0, 3'b000, 4'b1000);
    add(1, 1'b0, 3'b010, 4'b1000);
    add(1, 1'b0, 3'b000, 4'b1000);
    add(6, 1'b0, 3'b010, 4'b1000);   // then held
    add(1, 1'b0, 3'b010, 4'b0010);
    add(3, 1'b0, 3'b010, 4'b0000);
    add(6, 1'b0, 3'b000, 4'b0000);
    add(3, 1'b0, 3'b100, 4'b0000);   // 3-cycle glitch rejected
    add(6, 1'b0, 3'b000, 4'b0000);
    add(6, 1'b0, 3'b110, 4'b0000);   // up+down same edge
    add(1, 1'b0, 3'b110, 4'b0001);   // conflict only
    add(3, 1'b0, 3'b110, 4'b0000);
    add(6, 1'b0, 3'b000, 4'b0000);
    add(4, 1'b0, 3'b100, 4'b0000);   // go up before clear test
    add(2, 1'b0, 3'b000, 4'b0000);
    add(1, 1'b0, 3'b000, 4'b1010);
    add(3, 1'b0, 3'b000, 4'b1000);
    add(6, 1'b0, 3'b001, 4'b1000);   // clr held 20 cycles
    add(1, 1'b0, 3'b001, 4'b1100);
    add(13, 1'b0, 3'b001, 4'b1000);
    add(6, 1'b0, 3'b000, 4'b1000);
    add(4, 1'b0, 3'b001, 4'b1000);   // re-press clr
    add(2, 1'b0, 3'b000, 4'b1000);
    add(1, 1'b0, 3'b000, 4'b1100);
    add(4, 1'b0, 3'b000, 4'b1000);
    add(4, 1'b0, 3'b011, 4'b1000);   // clr + down same cycle
    add(2, 1'b0, 3'b000, 4'b1000);
    add(1, 1'b0, 3'b000, 4'b0110);
    add(5, 1'b0, 3'b000, 4'b0000);
`endif

    foreach (vecs[i]) begin
      apply_check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].btn, vecs[i].exp);
    end

    // Reset in the middle of a debounce discards the partial count; the
    // still-held button needs the full debounce after release.
    apply_check("rst_pre", 1'b1, 3'b000, 4'b0000);
    for (int i = 0; i < 2; i++) apply_check("md_press", 1'b0, 3'b100, 4'b0000);
    for (int i = 0; i < 2; i++) apply_check("md_rst", 1'b1, 3'b100, 4'b0000);
    for (int i = 0; i < 6; i++) apply_check("md_wait", 1'b0, 3'b100, 4'b0000);
    apply_check("md_accept", 1'b0, 3'b100, 4'b1010);
    apply_check("md_hold", 1'b0, 3'b100, 4'b1000);
    // Reset while up=1 returns direction to DOWN.
    apply_check("rst_up", 1'b1, 3'b100, 4'b0000);
    for (int i = 0; i < 3; i++) apply_check("post_rst", 1'b0, 3'b000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
